seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_scan_if.sv | 41 ++++
 rtl/tick_sync.sv | 38 +++
 rtl/seg7_scan.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scanner.
//   DEFAULT_NUM_DIGITS : digit count used when the top is not overridden
//   SEG_TABLE          : active-high hex glyphs, bit0=a ... bit6=g
//   scan_state_e       : scanner state (idle until the first step, then run)
//   hexToSeg()         : nibble -> active-high glyph lookup
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;

  // Entry n is the glyph for hex digit n; listed from F down to 0 so the
  // packed index matches the nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_if
// Bundles the scanner's data inputs and display outputs.
//   tick_clk   : divided scan tick (treated as async data)
//   en         : display enable
//   value      : 4*NUM_DIGITS hex nibbles, nibble i -> digit i
//   dp         : per-digit decimal point request
//   blank_lz   : leading-zero blanking request
//   seg        : segment drive, bit0=a ... bit6=g
//   dp_out     : decimal point of the active digit
//   an         : one-hot digit enable
//   frame_done : one-cycle pulse at each frame wrap
// master = the block feeding the display, slave = the scanner itself.
// ---------------------------------------------------------------------------
interface seg7_scan_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) ();

  logic                    tick_clk;
  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output tick_clk, en, value, dp, blank_lz,
    input  seg, dp_out, an, frame_done
  );

  modport slave (
    input  tick_clk, en, value, dp, blank_lz,
    output seg, dp_out, an, frame_done
  );

endinterface

// File: rtl/tick_sync.sv
// ---------------------------------------------------------------------------
// tick_sync
// Brings the divided scan tick into the clk_in domain and turns each rising
// edge of it into a single-cycle pulse.
//   clk_in : system clock
//   reset  : asynchronous active-low reset
//   d      : asynchronous level input (the scan tick)
//   rise   : one clk_in cycle high per synchronized rising edge of d
// ---------------------------------------------------------------------------
module tick_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two flops resolve metastability; the third holds the previous
  // synchronized level so a tick held high for many cycles still yields
  // exactly one pulse.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
// Time-multiplexes NUM_DIGITS hex digits onto one seven-segment bus. Each
// synchronized scan tick advances to the next digit; the display data is
// captured once per frame so every digit of a frame shows the same value.
//   clk_in : system clock, all state on its rising edge
//   reset  : asynchronous active-low reset
//   bus    : seg7_scan_if slave (tick_clk, en, value, dp, blank_lz in;
//            seg, dp_out, an, frame_done out)
// Parameters: NUM_DIGITS, SEG_ACTIVE_LOW (seg/dp_out low = lit),
//             AN_ACTIVE_LOW (an low = digit enabled).
// ---------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic        clk_in,
  input logic        reset,
  seg7_scan_if.slave bus
);

  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic                            step;
  scan_state_e                     state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      shadowValue_q, shadowValue_d;
  logic [NUM_DIGITS-1:0]           shadowDp_q, shadowDp_d;
  logic                            shadowBlank_q, shadowBlank_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dpOut_q, dpOut_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic                            frameDone_q, frameDone_d;

  logic                            loadSnap;
  logic                            showDigit;
  logic [NUM_DIGITS-1:0]           zeroFrom;
  logic                            allZero;
  logic                            blankDigit;
  logic [6:0]                      segHigh;
  logic                            dpHigh;
  logic [NUM_DIGITS-1:0]           anHigh;

  tick_sync u_tick_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (bus.tick_clk),
    .rise   (step)
  );

  // Scan sequencing. Disabling wins over a coincident step and parks the
  // scanner in idle at digit 0. The first step out of idle is not a wrap:
  // it captures a fresh snapshot and shows digit 0 without frame_done.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    loadSnap    = 1'b0;
    showDigit   = 1'b0;
    frameDone_d = 1'b0;
    if (!bus.en) begin
      state_d = SCAN_IDLE;
      idx_d   = '0;
    end else if (step) begin
      showDigit = 1'b1;
      case (state_q)
        SCAN_IDLE: begin
          state_d  = SCAN_RUN;
          idx_d    = '0;
          loadSnap = 1'b1;
        end
        SCAN_RUN: begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            loadSnap    = 1'b1;
            frameDone_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = SCAN_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Shadow registers only change when a new frame starts, so edits to the
  // inputs mid-frame never tear the displayed number.
  always_comb begin
    shadowValue_d = shadowValue_q;
    shadowDp_d    = shadowDp_q;
    shadowBlank_d = shadowBlank_q;
    if (loadSnap) begin
      shadowValue_d = bus.value;
      shadowDp_d    = bus.dp;
      shadowBlank_d = bus.blank_lz;
    end
  end

  // Glyph for the digit about to be shown. Decoding from the next-state
  // shadow and index lets the registered outputs change on the same edge
  // as idx. zeroFrom[i] is set when nibbles i..MSB are all zero; digit 0
  // is excluded from blanking so a zero value still shows "0".
  always_comb begin
    allZero  = 1'b1;
    zeroFrom = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allZero     = allZero & (shadowValue_d[i] == 4'h0);
      zeroFrom[i] = allZero;
    end
    blankDigit    = shadowBlank_d && (idx_d != '0) && zeroFrom[idx_d];
    segHigh       = blankDigit ? 7'h00 : hexToSeg(shadowValue_d[idx_d]);
    dpHigh        = shadowDp_d[idx_d];
    anHigh        = '0;
    anHigh[idx_d] = 1'b1;
  end

  // Output drive: blank everything while disabled, otherwise update only
  // on a step and hold the current digit in between.
  always_comb begin
    seg_d   = seg_q;
    dpOut_d = dpOut_q;
    an_d    = an_q;
    if (!bus.en) begin
      seg_d   = SEG_OFF;
      dpOut_d = DP_OFF;
      an_d    = AN_OFF;
    end else if (showDigit) begin
      seg_d   = SEG_ACTIVE_LOW ? ~segHigh : segHigh;
      dpOut_d = SEG_ACTIVE_LOW ? ~dpHigh : dpHigh;
      an_d    = AN_ACTIVE_LOW ? ~anHigh : anHigh;
    end
  end

  // All state, including the output registers, clears asynchronously so
  // the display goes dark the moment reset is asserted.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q       <= SCAN_IDLE;
      idx_q         <= '0;
      shadowValue_q <= '0;
      shadowDp_q    <= '0;
      shadowBlank_q <= 1'b0;
      seg_q         <= SEG_OFF;
      dpOut_q       <= DP_OFF;
      an_q          <= AN_OFF;
      frameDone_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadowValue_q <= shadowValue_d;
      shadowDp_q    <= shadowDp_d;
      shadowBlank_q <= shadowBlank_d;
      seg_q         <= seg_d;
      dpOut_q       <= dpOut_d;
      an_q          <= an_d;
      frameDone_q   <= frameDone_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_out     = dpOut_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
// Scoreboard bench for seg7_scan (4 digits, active-low segments and anodes).
// Stimulus pushes the expected display state for each scan tick; a monitor
// pops and compares whenever the anode pattern changes.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic   clk_in = 1'b0;
  logic   reset  = 1'b0;
  int     checks = 0;
  int     errors = 0;
  int     stepNo = 0;
  int     fdSeen = 0;
  int     firstFdCycle = 0;
  int     cycleCount = 0;
  exp_t   expQ[$];
  logic [3:0] prevAn;

  seg7_scan_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan #(
    .NUM_DIGITS     (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycleCount <= cycleCount + 1;

  function automatic exp_t mkExp(input logic [3:0] an, input logic [6:0] seg,
                                 input logic dp, input logic fd);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    e.fd  = fd;
    return e;
  endfunction

  function automatic exp_t sampleOut();
    return mkExp(bus.an, bus.seg, bus.dp_out, bus.frame_done);
  endfunction

  task automatic checkOutput(input string name, input exp_t expV, input exp_t actV);
    checks++;
    if (actV !== expV) begin
      errors++;
      $display("[TB] FAIL %s: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=%b",
               name, actV.an, actV.seg, actV.dp, actV.fd, expV.an, expV.seg, expV.dp, expV.fd);
    end
  endtask

  // One scan tick: high for highCycles, low for 4. Called just after a
  // rising edge so back-to-back calls give an 8-cycle tick period.
  task automatic applyStimulus(input bit expectUpdate, input logic [3:0] expAn,
                               input logic [6:0] expSeg, input logic expDp,
                               input logic expFd, input int highCycles);
    if (expectUpdate) expQ.push_back(mkExp(expAn, expSeg, expDp, expFd));
    #1 bus.tick_clk = 1'b1;
    repeat (highCycles) @(posedge clk_in);
    #1 bus.tick_clk = 1'b0;
    repeat (4) @(posedge clk_in);
  endtask

  // Monitor: every anode change is one displayed update and consumes one
  // scoreboard entry; frame_done outside such an update is a stray pulse.
  initial begin
    exp_t e;
    prevAn = 4'hF;
    forever begin
      @(negedge clk_in);
      if (!reset) begin
        prevAn = bus.an;
      end else if (bus.an !== prevAn) begin
        stepNo++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_update%0d: got an=%b seg=%h, expected no change",
                   stepNo, bus.an, bus.seg);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("step%0d", stepNo), e, sampleOut());
        end
        if (bus.frame_done === 1'b1) begin
          fdSeen++;
          if (fdSeen == 1) begin
            firstFdCycle = cycleCount;
          end else if (fdSeen == 2) begin
            checks++;
            if (cycleCount - firstFdCycle != 32) begin
              errors++;
              $display("[TB] FAIL frame_period: got %0d cycles, expected 32",
                       cycleCount - firstFdCycle);
            end
          end
        end
        prevAn = bus.an;
      end else if (bus.frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_frame_done: got %b, expected 0 (an=%b)", bus.frame_done, bus.an);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.tick_clk = 1'b0;
    bus.en       = 1'b0;
    bus.value    = 16'h0000;
    bus.dp       = 4'b0000;
    bus.blank_lz = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 checkOutput("reset_state", mkExp(4'hF, 7'h7F, 1'b1, 1'b0), sampleOut());
    @(negedge clk_in) reset = 1'b1;
    @(negedge clk_in) begin
      bus.en    = 1'b1;
      bus.value = 16'h1234;
    end
    @(posedge clk_in);

    $display("[TB] basic scan of 1234");
    applyStimulus(1, 4'b1110, ~7'h66, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1101, ~7'h4F, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h5B, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b0111, ~7'h06, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1110, ~7'h66, 1'b1, 1'b1, 4);
    applyStimulus(1, 4'b1101, ~7'h4F, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h5B, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b0111, ~7'h06, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1110, ~7'h66, 1'b1, 1'b1, 4);

    $display("[TB] leading-zero blanking of 0007");
    bus.value    = 16'h0007;
    bus.blank_lz = 1'b1;
    bus.dp       = 4'b0100;
    applyStimulus(1, 4'b1101, ~7'h4F, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h5B, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b0111, ~7'h06, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1110, ~7'h07, 1'b1, 1'b1, 4);
    applyStimulus(1, 4'b1101,  7'h7F, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011,  7'h7F, 1'b0, 1'b0, 4);
    applyStimulus(1, 4'b0111,  7'h7F, 1'b1, 1'b0, 4);
    bus.blank_lz = 1'b0;
    applyStimulus(1, 4'b1110, ~7'h07, 1'b1, 1'b1, 4);
    applyStimulus(1, 4'b1101, ~7'h3F, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h3F, 1'b0, 1'b0, 4);
    applyStimulus(1, 4'b0111, ~7'h3F, 1'b1, 1'b0, 4);

    $display("[TB] snapshot stability");
    bus.value = 16'hABCD;
    bus.dp    = 4'b0000;
    applyStimulus(1, 4'b1110, ~7'h5E, 1'b1, 1'b1, 4);
    applyStimulus(1, 4'b1101, ~7'h39, 1'b1, 1'b0, 4);
    bus.value = 16'h5555;
    applyStimulus(1, 4'b1011, ~7'h7C, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b0111, ~7'h77, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1110, ~7'h6D, 1'b1, 1'b1, 4);
    applyStimulus(1, 4'b1101, ~7'h6D, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h6D, 1'b1, 1'b0, 4);

    $display("[TB] enable drop at digit 2");
    expQ.push_back(mkExp(4'hF, 7'h7F, 1'b1, 1'b0));
    #1 bus.en = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("en_off_latency", mkExp(4'hF, 7'h7F, 1'b1, 1'b0), sampleOut());
    @(posedge clk_in);
    bus.value = 16'h89EF;
    bus.dp    = 4'b1000;
    applyStimulus(0, 4'hF, 7'h7F, 1'b1, 1'b0, 4);
    #1 bus.en = 1'b1;
    @(posedge clk_in);
    applyStimulus(1, 4'b1110, ~7'h71, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1101, ~7'h79, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h6F, 1'b1, 1'b0, 4);

    $display("[TB] enable drop coinciding with a step");
    expQ.push_back(mkExp(4'hF, 7'h7F, 1'b1, 1'b0));
    #1 bus.tick_clk = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 bus.en = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 bus.tick_clk = 1'b0;
    repeat (4) @(posedge clk_in);
    #1 bus.en = 1'b1;
    @(posedge clk_in);

    $display("[TB] long tick gives one step");
    applyStimulus(1, 4'b1110, ~7'h71, 1'b1, 1'b0, 20);
    applyStimulus(1, 4'b1101, ~7'h79, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1011, ~7'h6F, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b0111, ~7'h7F, 1'b0, 1'b0, 4);

    $display("[TB] asynchronous reset at digit 3");
    #3 reset = 1'b0;
    #1 checkOutput("async_reset", mkExp(4'hF, 7'h7F, 1'b1, 1'b0), sampleOut());
    @(negedge clk_in);
    @(negedge clk_in) reset = 1'b1;
    @(posedge clk_in);
    applyStimulus(1, 4'b1110, ~7'h71, 1'b1, 1'b0, 4);
    applyStimulus(1, 4'b1101, ~7'h79, 1'b1, 1'b0, 4);
    repeat (8) @(posedge clk_in);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending updates, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
